// File: rtl/hazard_pkg.sv
// Shared types and widths for the decode-stage hazard unit.
// The optional HAZARD_PERF_EN macro is consumed by hazard_unit, not here.
package hazard_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } sb_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-operand scoreboard lookup: youngest matching stage wins, and a load
// that is still too young to forward raises load_use.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_AVAIL = 2
) (
    input  logic [REG_W-1:0]                 rs_i,
    input  logic                             used_i,
    input  sb_entry_t [PIPE_DEPTH:1]         sb_i,
    output logic [sel_w(PIPE_DEPTH)-1:0]     sel_o,
    output logic                             load_use_o
);

    localparam int SEL_W = sel_w(PIPE_DEPTH);

    // Oldest-to-youngest scan so the youngest match overwrites older ones.
    always_comb begin
        sel_o      = '0;
        load_use_o = 1'b0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (used_i && (rs_i != '0) && sb_i[k].valid && sb_i[k].we &&
                (sb_i[k].rd == rs_i)) begin
                sel_o      = SEL_W'(k);
                load_use_o = sb_i[k].is_load && (k < LOAD_AVAIL);
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard-based bypass/stall generator for the decode stage.
// Define HAZARD_PERF_EN to add saturating stall/bypass event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_AVAIL = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     id_valid,
    input  logic [NUM_SRC-1:0][REG_W-1:0]            id_rs,
    input  logic [NUM_SRC-1:0]                       id_rs_used,
    input  logic [REG_W-1:0]                         id_rd,
    input  logic                                     id_rd_we,
    input  logic                                     id_is_load,
    input  logic                                     hold_in,
    input  logic                                     flush,
    output logic                                     stall,
    output logic                                     issue,
    output logic [NUM_SRC-1:0][sel_w(PIPE_DEPTH)-1:0] bypass_sel,
    output logic [REG_W-1:0]                         curr_rd
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                              perf_stall_cnt,
    output logic [31:0]                              perf_bypass_cnt
`endif
);

    sb_entry_t [PIPE_DEPTH:1] sb_q;
    sb_entry_t [PIPE_DEPTH:1] sb_d;
    logic [NUM_SRC-1:0]       src_load_use_s;
    logic                     load_use_s;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_src_match #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .LOAD_AVAIL (LOAD_AVAIL)
        ) u_match (
            .rs_i       (id_rs[s]),
            .used_i     (id_rs_used[s]),
            .sb_i       (sb_q),
            .sel_o      (bypass_sel[s]),
            .load_use_o (src_load_use_s[s])
        );
    end

    // Zero-latency decode-side controls; flush only suppresses issue.
    always_comb begin
        load_use_s = |src_load_use_s;
        stall      = load_use_s | hold_in;
        issue      = id_valid & ~stall & ~flush;
        if (sb_q[1].valid) begin
            curr_rd = sb_q[1].rd;
        end else begin
            curr_rd = '0;
        end
    end

    // Scoreboard next state: flush beats hold, hold freezes, otherwise shift.
    always_comb begin
        sb_d = sb_q;
        if (flush) begin
            sb_d = '0;
        end else if (hold_in) begin
            sb_d = sb_q;
        end else begin
            for (int k = PIPE_DEPTH; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            if (issue) begin
                sb_d[1] = '{valid:   1'b1,
                            rd:      id_rd,
                            we:      id_rd_we & (id_rd != '0),
                            is_load: id_is_load};
            end else begin
                sb_d[1] = '0;
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_bypass_q;
    logic        any_bypass_s;

    assign any_bypass_s = |bypass_sel;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= 32'd0;
            perf_bypass_q <= 32'd0;
        end else begin
            if (id_valid && load_use_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (issue && any_bypass_s && (perf_bypass_q != 32'hFFFF_FFFF)) begin
                perf_bypass_q <= perf_bypass_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = perf_stall_q;
    assign perf_bypass_cnt = perf_bypass_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (default parameters).
module tb_hazard_unit;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [1:0][4:0] id_rs;
    logic [1:0]      id_rs_used;
    logic [4:0]      id_rd;
    logic            id_rd_we;
    logic            id_is_load;
    logic            hold_in;
    logic            flush;
    logic            stall;
    logic            issue;
    logic [1:0][1:0] bypass_sel;
    logic [4:0]      curr_rd;
`ifdef HAZARD_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_bypass_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_rd_we   (id_rd_we),
        .id_is_load (id_is_load),
        .hold_in    (hold_in),
        .flush      (flush),
        .stall      (stall),
        .issue      (issue),
        .bypass_sel (bypass_sel),
        .curr_rd    (curr_rd)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bypass_cnt (perf_bypass_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic we,
                         input logic ld, input logic hold, input logic fl);
        id_valid   = v;
        id_rs[0]   = rs0;
        id_rs[1]   = rs1;
        id_rs_used = used;
        id_rd      = rd;
        id_rd_we   = we;
        id_is_load = ld;
        hold_in    = hold;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (bypass_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got=%h exp=0", bypass_sel); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_issue got=%0b exp=1", issue); end
        checks++; if (curr_rd !== 5'd0) begin errors++; $display("FAIL reset_curr_rd got=%0d exp=0", curr_rd); end
        tick();
    endtask

    task automatic test_forward();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (curr_rd !== 5'd5) begin errors++; $display("FAIL fwd_curr_rd got=%0d exp=5", curr_rd); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bypass_sel[0] !== exp_sel[i] || stall !== 1'b0) begin
                errors++;
                $display("FAIL fwd_age%0d sel got=%0d exp=%0d stall=%0b", i, bypass_sel[0], exp_sel[i], stall);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL lu_stall got stall=%0b issue=%0b exp 1/0", stall, issue); end
        checks++; if (bypass_sel[1] !== 2'd1) begin errors++; $display("FAIL lu_sel_stalled got=%0d exp=1", bypass_sel[1]); end
        tick();
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL lu_release got stall=%0b issue=%0b exp 0/1", stall, issue); end
        checks++; if (bypass_sel[1] !== 2'd2) begin errors++; $display("FAIL lu_sel got=%0d exp=2", bypass_sel[1]); end
        checks++; if (curr_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble_curr_rd got=%0d exp=0", curr_rd); end
        tick();
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd9, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bypass_sel !== {2'd1, 2'd1}) begin errors++; $display("FAIL young_sel got=%h exp=5", bypass_sel); end
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bypass_sel !== 4'b0000) begin errors++; $display("FAIL r0_sel got=%h exp=0", bypass_sel); end
        tick();
    endtask

    task automatic test_hold_flush();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bypass_sel[0] !== 2'd1 || issue !== 1'b0 || stall !== 1'b1 || curr_rd !== 5'd4) begin
                errors++;
                $display("FAIL hold%0d sel=%0d issue=%0b stall=%0b rd=%0d exp 1/0/1/4", i, bypass_sel[0], issue, stall, curr_rd);
            end
            tick();
        end
        drive(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue got=%0b exp=0", issue); end
        tick();
        drive(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bypass_sel !== 4'b0000 || curr_rd !== 5'd0 || stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty sel=%h rd=%0d stall=%0b issue=%0b exp 0/0/0/1", bypass_sel, curr_rd, stall, issue);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%0b exp=1", stall); end
        tick();
        rst = 1'b0;
        drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0 || bypass_sel[1] !== 2'd0) begin errors++; $display("FAIL rst_mid_post stall=%0b sel=%0d exp 0/0", stall, bypass_sel[1]); end
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            tick();
        end
        checks++; if (perf_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt); end
        checks++; if (perf_bypass_cnt !== 32'd2) begin errors++; $display("FAIL perf_bypass got=%0d exp=2", perf_bypass_cnt); end
        do_reset();
        checks++; if (perf_stall_cnt !== 32'd0 || perf_bypass_cnt !== 32'd0) begin errors++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", perf_stall_cnt, perf_bypass_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_hold_flush();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised successor to the fixed bypass/stall flag pair between ControlPath and DataPath.
- Keeps a shift-register scoreboard of in-flight destination registers for PIPE_DEPTH stages after decode.
- For each of NUM_SRC decode-stage source operands, produces a per-operand bypass select and a single stall.
- Handles load-use latency, downstream back-pressure and pipeline flush.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
- NUM_SRC, 2, source operands checked per decoded instruction.
- PIPE_DEPTH, 3, tracked stages after decode (1=EX, 2=MEM, 3=WB).
- LOAD_AVAIL, 2, first stage at which a load result is forwardable (1 <= LOAD_AVAIL <= PIPE_DEPTH).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs  in  NUM_SRC x $clog2(NUM_REGS)  source register indices
- id_rs_used  in  NUM_SRC  source operand is actually read
- id_rd  in  $clog2(NUM_REGS)  destination register index
- id_rd_we  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- hold_in  in  1  downstream back-pressure (e.g. memory wait)
- flush  in  1  branch/exception redirect
- stall  out  1  decode must hold this cycle
- issue  out  1  id_valid & ~stall & ~flush
- bypass_sel  out  NUM_SRC x $clog2(PIPE_DEPTH+1)  0=regfile, k=forward from stage k
- curr_rd  out  $clog2(NUM_REGS)  rd of the stage-1 entry (0 if invalid)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Scoreboard: PIPE_DEPTH entries {valid, rd, we, is_load}. Entry k is the instruction k stages past decode.
- Reset: all entries invalid. While empty: stall=0, bypass_sel=0, curr_rd=0, issue=id_valid.
- Outputs stall, issue, bypass_sel are combinational from the id_* inputs and registered state; zero-cycle latency.
- Match: source s matches entry k iff id_rs_used[s], entry k valid & we, rd==id_rs[s], and id_rs[s]!=0.
- Forwarding priority: youngest matching stage (smallest k) wins. bypass_sel[s]=k, or 0 if nothing matches.
- Load-use stall: the winning match for any source has is_load=1 and k < LOAD_AVAIL -> stall=1.
- stall = load_use | hold_in. The flush term appears only in issue.
- On every posedge when not rst:
  - hold_in=1: scoreboard holds unchanged. Stage 1 is not a bubble.
  - hold_in=0: entries shift k->k+1; the oldest entry retires.
  - Stage 1 loads {issue, id_rd, id_rd_we & (id_rd!=0), id_is_load}. A bubble is inserted when issue=0.
- Flush: all entries invalid on the next edge; issue forced 0 that cycle. flush takes priority over hold_in.
- Simultaneous rst and flush: rst wins (same result).
- Reset mid-stall clears the scoreboard; stall drops the next cycle unless hold_in is high.
- bypass_sel is valid even while stall=1; consumers ignore it then.
- Retirement from stage PIPE_DEPTH: the regfile write-through handles same-cycle read; no match remains.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0] and perf_bypass_cnt[31:0]:
  - Both 0 at reset and saturate at all-ones.
  - perf_stall_cnt increments each cycle with id_valid & load_use.
  - perf_bypass_cnt increments each cycle issue=1 with any bypass_sel!=0.
- When undefined, these ports and counters do not exist.

Decomposition:
- hazard_pkg holds:
  - REG_W = $clog2(NUM_REGS).
  - sb_entry_t packed struct {valid, rd, we, is_load}.
  - Function sel_w(depth) returning $clog2(depth+1).
- One sub-module, hazard_src_match: instantiated NUM_SRC times; takes the rs index, the used flag and the scoreboard array; returns bypass_sel and a load_use bit.

Test Plan:
- After reset, id_rs={5,6}, id_valid=1 -> stall=0, bypass_sel={0,0}, issue=1.
- Issue ADD rd=5, then next cycle rs0=5 -> bypass_sel[0]=1. One cycle later -> 2, then 3, then 0.
- LOAD rd=7, then next cycle rs1=7 -> stall=1 for one cycle, then bypass_sel[1]=2 with stall=0.
- Stage 1 and stage 2 both write rd=9 -> bypass_sel=1 (youngest). rd=0 writer with rs=0 -> bypass_sel=0.
- hold_in=1 for 3 cycles with rd=4 in stage 1 -> scoreboard frozen, bypass_sel stays 1, issue=0. flush then empties all entries.
- HAZARD_PERF_EN: the load-use sequence above twice -> perf_stall_cnt=2; counters clear on rst.
